// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the trap sequencer: privilege levels, FSM states,
// commit commands and the fixed interrupt priority order.
package trap_ctrl_pkg;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_M = 2'b11;

  localparam logic [1:0] TVEC_VECTORED = 2'b01;

  localparam int unsigned IRQ_CODE_W = 4;
  localparam int unsigned IRQ_NUM    = 6;

  localparam logic [IRQ_CODE_W-1:0] IRQ_MEI = 4'd11;
  localparam logic [IRQ_CODE_W-1:0] IRQ_MSI = 4'd3;
  localparam logic [IRQ_CODE_W-1:0] IRQ_MTI = 4'd7;
  localparam logic [IRQ_CODE_W-1:0] IRQ_SEI = 4'd9;
  localparam logic [IRQ_CODE_W-1:0] IRQ_SSI = 4'd1;
  localparam logic [IRQ_CODE_W-1:0] IRQ_STI = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_TRAP_M,
    CMD_TRAP_S,
    CMD_RET_M,
    CMD_RET_S
  } cmd_e;

  // Interrupt code at a given priority rank (0 = highest).
  function automatic logic [IRQ_CODE_W-1:0] irq_prio_code(input int rank);
    case (rank)
      0:       irq_prio_code = IRQ_MEI;
      1:       irq_prio_code = IRQ_MSI;
      2:       irq_prio_code = IRQ_MTI;
      3:       irq_prio_code = IRQ_SEI;
      4:       irq_prio_code = IRQ_SSI;
      default: irq_prio_code = IRQ_STI;
    endcase
  endfunction

  function automatic logic irq_enabled(input logic [1:0] prv, input logic tgt_s,
                                       input logic mie, input logic sie);
    if (tgt_s) irq_enabled = (prv < PRV_S) || ((prv == PRV_S) && sie);
    else       irq_enabled = (prv < PRV_M) || mie;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_arb.sv
// Combinational interrupt resolution: picks the highest-priority pending
// interrupt that is enabled for its (possibly delegated) target privilege.
module trap_ctrl_irq_arb
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN_P = 32
) (
  input  logic [XLEN_P-1:0]     pend_i,
  input  logic [XLEN_P-1:0]     deleg_i,
  input  logic [1:0]            prv_i,
  input  logic                  mie_i,
  input  logic                  sie_i,
  output logic                  take_c,
  output logic [IRQ_CODE_W-1:0] code_c,
  output logic                  tgt_s_c
);

  logic [IRQ_CODE_W-1:0] cand;
  logic                  cand_s;
  logic                  cand_pend;

  // Walk lowest to highest priority so the highest enabled candidate wins.
  always_comb begin
    take_c    = 1'b0;
    code_c    = '0;
    tgt_s_c   = 1'b0;
    cand      = '0;
    cand_s    = 1'b0;
    cand_pend = 1'b0;
    for (int r = int'(IRQ_NUM) - 1; r >= 0; r--) begin
      cand      = irq_prio_code(r);
      cand_s    = (prv_i <= PRV_S) && (|(deleg_i & (XLEN_P'(1) << cand)));
      cand_pend = |(pend_i & (XLEN_P'(1) << cand));
      if (cand_pend && irq_enabled(prv_i, cand_s, mie_i, sie_i)) begin
        take_c  = 1'b1;
        code_c  = cand;
        tgt_s_c = cand_s;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/xRET sequencer: arbitrates requests in IDLE, drains the pipeline,
// issues one CSR commit strobe and redirects fetch.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN_P = 32,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              trap_en,
  input  logic [XLEN_P-1:0] trap_cause,
  input  logic [PC_W-1:0]   trap_epc,
  input  logic [XLEN_P-1:0] trap_val,
  input  logic [XLEN_P-1:0] irq_pend,
  input  logic              irq_epc_valid,
  input  logic [PC_W-1:0]   irq_epc,
  input  logic              mret,
  input  logic              sret,
  input  logic [1:0]        prv_cur,
  input  logic              mstatus_mie,
  input  logic              mstatus_sie,
  input  logic [XLEN_P-1:0] medeleg,
  input  logic [XLEN_P-1:0] mideleg,
  input  logic [XLEN_P-1:0] mtvec,
  input  logic [XLEN_P-1:0] stvec,
  input  logic [XLEN_P-1:0] mepc,
  input  logic [XLEN_P-1:0] sepc,
  input  logic              bus_idle,
  input  logic              fetch_rdy,
  output logic              busy,
  output logic              flush,
  output logic              csr_trap_m_we,
  output logic              csr_trap_s_we,
  output logic              csr_ret_m_we,
  output logic              csr_ret_s_we,
  output logic [XLEN_P-1:0] csr_cause,
  output logic [PC_W-1:0]   csr_epc,
  output logic [XLEN_P-1:0] csr_tval,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc
);

  state_e                state_q, state_d;
  cmd_e                  cmd_q, cmd_d;
  logic [XLEN_P-1:0]     cause_q, cause_d;
  logic [PC_W-1:0]       epc_q, epc_d;
  logic [XLEN_P-1:0]     tval_q, tval_d;
  logic [PC_W-1:0]       tgt_pc_q, tgt_pc_d;
  logic                  busy_q, flush_q, rv_q;
  logic                  tm_we_q, ts_we_q, rm_we_q, rs_we_q;

  logic                  irq_take;
  logic [IRQ_CODE_W-1:0] irq_code;
  logic                  irq_tgt_s;
  logic                  exc_tgt_s;
  logic [XLEN_P-1:0]     irq_tvec, exc_tvec;
  logic [PC_W-1:0]       irq_pc, exc_pc;

  trap_ctrl_irq_arb #(.XLEN_P(XLEN_P)) u_irq_arb (
    .pend_i  (irq_pend),
    .deleg_i (mideleg),
    .prv_i   (prv_cur),
    .mie_i   (mstatus_mie),
    .sie_i   (mstatus_sie),
    .take_c  (irq_take),
    .code_c  (irq_code),
    .tgt_s_c (irq_tgt_s)
  );

  // Next-state, capture and vector target resolution.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    tgt_pc_d  = tgt_pc_q;
    exc_tgt_s = (prv_cur <= PRV_S) && (|(medeleg & (XLEN_P'(1) << trap_cause)));
    exc_tvec  = exc_tgt_s ? stvec : mtvec;
    exc_pc    = PC_W'(exc_tvec) & ~PC_W'(3);
    irq_tvec  = irq_tgt_s ? stvec : mtvec;
    irq_pc    = PC_W'(irq_tvec) & ~PC_W'(3);
    if (irq_tvec[1:0] == TVEC_VECTORED) irq_pc = irq_pc + (PC_W'(irq_code) << 2);

    case (state_q)
      ST_IDLE: begin
        if (trap_en) begin
          cmd_d    = exc_tgt_s ? CMD_TRAP_S : CMD_TRAP_M;
          cause_d  = trap_cause;
          epc_d    = trap_epc;
          tval_d   = trap_val;
          tgt_pc_d = exc_pc;
          state_d  = ST_DRAIN;
        end else if (irq_epc_valid && irq_take) begin
          cmd_d    = irq_tgt_s ? CMD_TRAP_S : CMD_TRAP_M;
          cause_d  = {1'b1, (XLEN_P-1)'(irq_code)};
          epc_d    = irq_epc;
          tval_d   = '0;
          tgt_pc_d = irq_pc;
          state_d  = ST_DRAIN;
        end else if (mret) begin
          cmd_d    = CMD_RET_M;
          tgt_pc_d = PC_W'(mepc);
          state_d  = ST_DRAIN;
        end else if (sret) begin
          cmd_d    = CMD_RET_S;
          tgt_pc_d = PC_W'(sepc);
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN:    if (bus_idle) state_d = ST_COMMIT;
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: if (fetch_rdy) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_NONE;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      tgt_pc_q <= '0;
      busy_q   <= 1'b0;
      flush_q  <= 1'b0;
      rv_q     <= 1'b0;
      tm_we_q  <= 1'b0;
      ts_we_q  <= 1'b0;
      rm_we_q  <= 1'b0;
      rs_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      tgt_pc_q <= tgt_pc_d;
      busy_q   <= (state_d != ST_IDLE);
      flush_q  <= (state_d == ST_DRAIN);
      rv_q     <= (state_d == ST_REDIRECT);
      tm_we_q  <= (state_d == ST_COMMIT) && (cmd_d == CMD_TRAP_M);
      ts_we_q  <= (state_d == ST_COMMIT) && (cmd_d == CMD_TRAP_S);
      rm_we_q  <= (state_d == ST_COMMIT) && (cmd_d == CMD_RET_M);
      rs_we_q  <= (state_d == ST_COMMIT) && (cmd_d == CMD_RET_S);
    end
  end

  assign busy           = busy_q;
  assign flush          = flush_q;
  assign csr_trap_m_we  = tm_we_q;
  assign csr_trap_s_we  = ts_we_q;
  assign csr_ret_m_we   = rm_we_q;
  assign csr_ret_s_we   = rs_we_q;
  assign csr_cause      = cause_q;
  assign csr_epc        = epc_q;
  assign csr_tval       = tval_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = tgt_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: table of single-shot sequences plus
// hand-written drain/handshake stretch and async-reset cases.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        trap_en;
  logic [31:0] trap_cause, trap_epc, trap_val, irq_pend, irq_epc;
  logic        irq_epc_valid, mret, sret;
  logic [1:0]  prv_cur;
  logic        mstatus_mie, mstatus_sie;
  logic [31:0] medeleg, mideleg, mtvec, stvec, mepc, sepc;
  logic        bus_idle, fetch_rdy;
  logic        busy, flush, csr_trap_m_we, csr_trap_s_we, csr_ret_m_we, csr_ret_s_we;
  logic [31:0] csr_cause, csr_epc, csr_tval, redirect_pc;
  logic        redirect_valid;
  logic [3:0]  stb;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign stb = {csr_trap_m_we, csr_trap_s_we, csr_ret_m_we, csr_ret_s_we};

  trap_ctrl #(.XLEN_P(32), .PC_W(32)) dut (
    .clk(clk), .rstn(rstn), .trap_en(trap_en), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_val(trap_val), .irq_pend(irq_pend),
    .irq_epc_valid(irq_epc_valid), .irq_epc(irq_epc), .mret(mret), .sret(sret),
    .prv_cur(prv_cur), .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie),
    .medeleg(medeleg), .mideleg(mideleg), .mtvec(mtvec), .stvec(stvec),
    .mepc(mepc), .sepc(sepc), .bus_idle(bus_idle), .fetch_rdy(fetch_rdy),
    .busy(busy), .flush(flush), .csr_trap_m_we(csr_trap_m_we),
    .csr_trap_s_we(csr_trap_s_we), .csr_ret_m_we(csr_ret_m_we),
    .csr_ret_s_we(csr_ret_s_we), .csr_cause(csr_cause), .csr_epc(csr_epc),
    .csr_tval(csr_tval), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic        trap_en;
    logic [31:0] cause, epc, tval, irq_pend;
    logic        irq_v;
    logic [31:0] irq_epc;
    logic        mret, sret;
    logic [1:0]  prv;
    logic        mie, sie;
    logic [31:0] medeleg, mideleg, mtvec, stvec, mepc, sepc;
    logic [3:0]  e_stb;
    logic        e_csr;
    logic [31:0] e_cause, e_epc, e_tval, e_pc;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_req();
    trap_en = 1'b0; irq_pend = '0; irq_epc_valid = 1'b0; mret = 1'b0; sret = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    trap_en = v.trap_en; trap_cause = v.cause; trap_epc = v.epc; trap_val = v.tval;
    irq_pend = v.irq_pend; irq_epc_valid = v.irq_v; irq_epc = v.irq_epc;
    mret = v.mret; sret = v.sret; prv_cur = v.prv;
    mstatus_mie = v.mie; mstatus_sie = v.sie;
    medeleg = v.medeleg; mideleg = v.mideleg; mtvec = v.mtvec; stvec = v.stvec;
    mepc = v.mepc; sepc = v.sepc;
  endtask

  // Request in cycle N with bus_idle=1 and fetch_rdy=1.
  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk); apply(v);
    @(negedge clk); clear_req();
    chk($sformatf("v%0d busy N+1", i), 32'(busy), 32'd1);
    chk($sformatf("v%0d flush N+1", i), 32'(flush), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d strobe N+2", i), 32'(stb), 32'(v.e_stb));
    chk($sformatf("v%0d flush N+2", i), 32'(flush), 32'd0);
    if (v.e_csr) begin
      chk($sformatf("v%0d cause", i), csr_cause, v.e_cause);
      chk($sformatf("v%0d epc", i), csr_epc, v.e_epc);
      chk($sformatf("v%0d tval", i), csr_tval, v.e_tval);
    end
    @(negedge clk);
    chk($sformatf("v%0d redirect_valid N+3", i), 32'(redirect_valid), 32'd1);
    chk($sformatf("v%0d redirect_pc", i), redirect_pc, v.e_pc);
    chk($sformatf("v%0d strobe N+3", i), 32'(stb), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d busy N+4", i), 32'(busy), 32'd0);
    chk($sformatf("v%0d redirect_valid N+4", i), 32'(redirect_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " flush"}, 32'(flush), 32'd0);
    chk({tag, " strobes"}, 32'(stb), 32'd0);
    chk({tag, " redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, " redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, " cause"}, csr_cause, 32'd0);
    chk({tag, " epc"}, csr_epc, 32'd0);
    chk({tag, " tval"}, csr_tval, 32'd0);
  endtask

  initial begin
    int nflush, nstb, nrv, nbusy;

    vecs[0]  = '{trap_en:1'b1, cause:32'd2, epc:32'h80000100, prv:2'd3, mtvec:32'h80000000,
                 e_stb:4'b1000, e_csr:1'b1, e_cause:32'd2, e_epc:32'h80000100, e_pc:32'h80000000, default:0};
    vecs[1]  = '{trap_en:1'b1, cause:32'd8, epc:32'h80000200, prv:2'd0, medeleg:32'h100,
                 mtvec:32'h80000000, stvec:32'h80200000,
                 e_stb:4'b0100, e_csr:1'b1, e_cause:32'd8, e_epc:32'h80000200, e_pc:32'h80200000, default:0};
    vecs[2]  = '{irq_pend:32'h80, irq_v:1'b1, irq_epc:32'h80000404, prv:2'd3, mie:1'b1, mtvec:32'h80000001,
                 e_stb:4'b1000, e_csr:1'b1, e_cause:32'h80000007, e_epc:32'h80000404, e_pc:32'h8000001C, default:0};
    vecs[3]  = '{trap_en:1'b1, cause:32'd2, epc:32'h80001000, tval:32'hDEADBEEF, mret:1'b1,
                 mepc:32'h80003000, prv:2'd3, mtvec:32'h80000000,
                 e_stb:4'b1000, e_csr:1'b1, e_cause:32'd2, e_epc:32'h80001000, e_tval:32'hDEADBEEF,
                 e_pc:32'h80000000, default:0};
    vecs[4]  = '{irq_pend:32'h88, irq_v:1'b1, irq_epc:32'h80000500, prv:2'd3, mie:1'b1, mtvec:32'h80000001,
                 e_stb:4'b1000, e_csr:1'b1, e_cause:32'h80000003, e_epc:32'h80000500, e_pc:32'h8000000C, default:0};
    vecs[5]  = '{mret:1'b1, mepc:32'h80001234, prv:2'd3, e_stb:4'b0010, e_pc:32'h80001234, default:0};
    vecs[6]  = '{sret:1'b1, sepc:32'h80004000, prv:2'd1, e_stb:4'b0001, e_pc:32'h80004000, default:0};
    vecs[7]  = '{irq_pend:32'h80, mie:1'b1, prv:2'd3, mret:1'b1, mepc:32'h80005000,
                 e_stb:4'b0010, e_pc:32'h80005000, default:0};
    vecs[8]  = '{irq_pend:32'h20, irq_v:1'b1, irq_epc:32'h80000600, mideleg:32'h20, prv:2'd0,
                 stvec:32'h80200000, mtvec:32'h80000000,
                 e_stb:4'b0100, e_csr:1'b1, e_cause:32'h80000005, e_epc:32'h80000600, e_pc:32'h80200000, default:0};
    vecs[9]  = '{irq_pend:32'h80, irq_v:1'b1, prv:2'd3, sret:1'b1, sepc:32'h80006000,
                 e_stb:4'b0001, e_pc:32'h80006000, default:0};
    vecs[10] = '{trap_en:1'b1, cause:32'd3, epc:32'h80000010, tval:32'h80000010, medeleg:32'h8,
                 prv:2'd3, mtvec:32'h80000101,
                 e_stb:4'b1000, e_csr:1'b1, e_cause:32'd3, e_epc:32'h80000010, e_tval:32'h80000010,
                 e_pc:32'h80000100, default:0};
    vecs[11] = '{irq_pend:32'h200, irq_v:1'b1, irq_epc:32'h80000700, mideleg:32'h200, prv:2'd1,
                 sie:1'b1, stvec:32'h80200001,
                 e_stb:4'b0100, e_csr:1'b1, e_cause:32'h80000009, e_epc:32'h80000700, e_pc:32'h80200024, default:0};
    vecs[12] = '{irq_pend:32'h220, irq_v:1'b1, irq_epc:32'h80000800, mideleg:32'h200, prv:2'd1,
                 mtvec:32'h80000001,
                 e_stb:4'b1000, e_csr:1'b1, e_cause:32'h80000005, e_epc:32'h80000800, e_pc:32'h80000014, default:0};

    rstn = 1'b0;
    apply(vecs[0]);
    clear_req();
    bus_idle = 1'b1; fetch_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Drain and handshake stretch with a stray trap_en mid-sequence.
    nflush = 0; nstb = 0; nrv = 0; nbusy = 0;
    @(negedge clk);
    apply(vecs[0]);
    trap_epc = 32'h80000900; trap_val = 32'h11;
    bus_idle = 1'b0; fetch_rdy = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (flush) nflush++;
      if (stb != 4'b0) nstb++;
      if (busy) nbusy++;
      if (redirect_valid) begin
        nrv++;
        chk($sformatf("stretch redirect_pc c%0d", cyc), redirect_pc, 32'h80000000);
      end
      if (cyc == 7) chk("stretch strobe kind", 32'(stb), 32'h8);
      trap_en    = (cyc >= 2 && cyc <= 4);
      trap_cause = 32'd5;
      bus_idle   = (cyc >= 6);
      fetch_rdy  = (cyc >= 11);
    end
    chk("stretch flush cycles", 32'(nflush), 32'd6);
    chk("stretch strobe count", 32'(nstb), 32'd1);
    chk("stretch redirect cycles", 32'(nrv), 32'd4);
    chk("stretch busy cycles", 32'(nbusy), 32'd11);
    chk("stretch cause kept", csr_cause, 32'd2);
    chk("stretch epc kept", csr_epc, 32'h80000900);
    chk("stretch tval kept", csr_tval, 32'h11);

    // Async reset while waiting in REDIRECT.
    bus_idle = 1'b1; fetch_rdy = 1'b0;
    @(negedge clk); apply(vecs[1]);
    @(negedge clk); clear_req();
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset redirect_valid", 32'(redirect_valid), 32'd1);
    #2 rstn = 1'b0;
    #1 chk_all_zero("async reset");
    @(negedge clk);
    rstn = 1'b1; fetch_rdy = 1'b1;
    chk_all_zero("after release");
    run_vec(100, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Sequencer between the combinational trap-priority unit and the CSR/fetch logic. It arbitrates synchronous exceptions, interrupts and xRET requests, and resolves M/S delegation. It then drains the pipeline, issues single-cycle CSR commit strobes and redirects fetch to the trap vector or return address. While a sequence is in progress it holds the pipeline stalled through `busy`.

Parameters:
- XLEN_P, `XLEN, datapath and CSR width.
- PC_W, `IM_ADDR_LEN, PC width.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- trap_en  in  1  exception request from the trap-priority unit.
- trap_cause  in  XLEN_P  exception cause code (MSB=0).
- trap_epc  in  PC_W  faulting PC.
- trap_val  in  XLEN_P  tval for the exception.
- irq_pend  in  XLEN_P  mip & mie.
- irq_epc_valid  in  1  a committed next-PC exists; interrupts may be taken this cycle.
- irq_epc  in  PC_W  next PC to resume after an interrupt.
- mret, sret  in  1  xRET retiring this cycle.
- prv_cur  in  2  current privilege.
- mstatus_mie, mstatus_sie  in  1  global interrupt enables.
- medeleg, mideleg  in  XLEN_P  delegation masks.
- mtvec, stvec, mepc, sepc  in  XLEN_P  CSR values.
- bus_idle  in  1  no outstanding I/D bus transactions.
- fetch_rdy  in  1  fetch accepts the redirect.
- busy  out  1  sequence active; pipeline must stall.
- flush  out  1  kill all in-flight instructions.
- csr_trap_m_we, csr_trap_s_we  out  1  one-cycle strobes: write xepc/xcause/xtval, update xstatus, set prv.
- csr_ret_m_we, csr_ret_s_we  out  1  one-cycle xRET status/prv restore strobes.
- csr_cause  out  XLEN_P  latched cause.
- csr_epc  out  PC_W  latched epc.
- csr_tval  out  XLEN_P  latched tval.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  PC_W  redirect target.

Behaviour:
- Reset: state IDLE; every output and every capture register is 0. Asserting rstn low mid-sequence aborts immediately to IDLE; no partial strobe is issued.
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE arbitration, one winner per cycle: trap_en > pending enabled interrupt (only when irq_epc_valid) > mret > sret.
  - trap_en with mret in the same cycle: the trap wins and the mret is dropped.
- Interrupt selection: fixed priority on bits 11, 3, 7, 9, 1, 5. Code = bit index; cause = {1'b1, code}.
- Target privilege: S if prv_cur ≤ S and the deleg bit (medeleg[cause] for exceptions, mideleg[code] for interrupts) is 1; otherwise M. xRET has no target resolution: the instruction itself names M or S.
- Interrupt enable: an M-target interrupt is taken if prv_cur < M or mstatus_mie. An S-target interrupt is taken if prv_cur < S, or prv_cur==S and mstatus_sie.
- Capture on the winning cycle N:
  - Exception: cause, epc and tval come from the trap_* inputs.
  - Interrupt: epc = irq_epc, tval = 0.
  - Redirect target for a trap: tvec[PC_W-1:2]<<2. If tvec[1:0]==1 and the request is an interrupt, add 4*code.
  - Redirect target for xRET: mepc or sepc.
  - State goes to DRAIN.
- DRAIN (from N+1): busy=1 and flush=1. Remain until bus_idle=1, then go to COMMIT.
- COMMIT (exactly 1 cycle): busy=1, flush=0. Exactly one of the four csr_*_we strobes is 1. csr_cause/epc/tval are stable from capture until the next capture. Next state is REDIRECT.
- REDIRECT: busy=1, redirect_valid=1, redirect_pc stable. Hold until fetch_rdy=1; on that cycle return to IDLE.
- busy is registered and asserted from N+1 until the cycle after the fetch handshake.
- Minimum latency: trap_en at N → strobe at N+2 → redirect_valid at N+3 (bus_idle=1, fetch_rdy=1).
- Outside IDLE, trap_en, irq_pend, mret and sret are ignored.
- Unused cause MSB-clear codes are passed through unchanged. Width truncation to PC_W applies on tvec/epc.

Decomposition:
- cpu_define.h / shared package: PRV_U/S/M encodings; state enum; interrupt code constants (11, 3, 7, 9, 1, 5); vector-mode encoding.
- Sub-module irq_arb: combinational pending/enable/delegation resolution returning take, code and target privilege. It is reused by debug/WFI wakeup logic.

Test Plan:
- Illegal instruction at prv_cur=M: trap_en=1, cause=2, epc=0x80000100, tval=0x00000000, mtvec=0x80000000, bus_idle=1, fetch_rdy=1 → csr_trap_m_we at N+2 with cause=2, epc=0x80000100; redirect_pc=0x80000000 at N+3.
- U-mode ecall delegated: prv_cur=U, cause=8, medeleg[8]=1, stvec=0x80200000 → csr_trap_s_we only; redirect_pc=0x80200000.
- Vectored interrupt: irq_pend bit 7 set, mstatus_mie=1, prv_cur=M, mtvec=0x80000001, irq_epc=0x80000404 → cause=0x80000007, epc=0x80000404, tval=0, redirect_pc=0x8000001C.
- Exception/mret conflict and priority: trap_en and mret in the same cycle → trap sequence only, no csr_ret_m_we. irq bits 3 and 7 both pending → code 3 is taken.
- Drain and handshake stretch: bus_idle held low 5 cycles, fetch_rdy low 3 cycles → flush held 6 cycles, a single strobe, redirect_valid held until fetch_rdy; a new trap_en during the sequence is ignored.
- Async reset: rstn low while in REDIRECT → all outputs 0 immediately. After release, state is IDLE and a new trap is accepted normally.
